// File: rtl/elm_seq_pkg.sv
// Shared types, default sizes and width helper for the ELM layer sequencer.
package elm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        EMIT
    } state_e;

    localparam int DEF_NUM_INPUTS  = 128;
    localparam int DEF_NUM_NEURONS = 16;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_OUT_WIDTH   = 16;
    localparam int DEF_TIMEOUT     = 64;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elm_out_capture.sv
// Per-neuron done mask and activation capture bank for one layer pass.
module elm_out_capture
    import elm_seq_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int IDX_W       = cnt_w(NUM_NEURONS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [NUM_NEURONS-1:0]         nrn_outvalid,
    input  logic [NUM_NEURONS*OUT_WIDTH-1:0] nrn_out,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic                           done_all,
    output logic [OUT_WIDTH-1:0]           rd_data
);

    logic [NUM_NEURONS-1:0] done_q;
    logic [NUM_NEURONS-1:0] done_d;
    logic [OUT_WIDTH-1:0]   cap_q [NUM_NEURONS];
    logic [OUT_WIDTH-1:0]   cap_d [NUM_NEURONS];

    // Only the first pulse of each neuron is captured; later ones are ignored.
    always_comb begin
        done_d = done_q;
        cap_d  = cap_q;
        if (clear) begin
            done_d = '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cap_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (nrn_outvalid[i] && !done_q[i]) begin
                    done_d[i] = 1'b1;
                    cap_d[i]  = nrn_out[i*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

    // Looking at next-state values lets a capture be emitted on the same edge.
    assign done_all = &done_d;
    assign rd_data  = cap_d[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            done_q <= done_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cap_q[i] <= cap_d[i];
            end
        end
    end

endmodule

// File: rtl/elm_layer_sequencer.sv
// Feeds one feature vector to an ELM hidden layer, collects every neuron's
// activation and streams the results out one neuron per beat.
module elm_layer_sequencer
    import elm_seq_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            nrn_input,
    output logic                             nrn_input_valid,
    input  logic [NUM_NEURONS-1:0]           nrn_outvalid,
    input  logic [NUM_NEURONS*OUT_WIDTH-1:0] nrn_out,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_NEURONS)-1:0]   out_index,
    output logic                             out_valid,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             err_len,
    output logic                             err_timeout,
    output logic [15:0]                      frame_cnt
);

    localparam int BEAT_W = cnt_w(NUM_INPUTS + 1);
    localparam int IDX_W  = $clog2(NUM_NEURONS);
    localparam int TMR_W  = cnt_w(TIMEOUT + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_INPUTS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT);

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  din_vld_q, din_vld_d;
    logic [OUT_WIDTH-1:0]  odata_q, odata_d;
    logic                  ovalid_q, ovalid_d;
    logic                  olast_q, olast_d;
    logic                  err_len_q, err_len_d;
    logic                  err_to_q, err_to_d;
    logic [15:0]           frame_q, frame_d;

    logic                   accept;
    logic                   hs;
    logic [BEAT_W-1:0]      beat_nx;
    logic                   final_beat;
    logic                   cap_clear;
    logic [NUM_NEURONS-1:0] cap_vld;
    logic [IDX_W-1:0]       rd_idx;
    logic                   done_all;
    logic [OUT_WIDTH-1:0]   rd_data;

    // Gated by rst so every output reads 0 while reset is held.
    assign in_ready   = !rst && (state_q == IDLE || state_q == FEED);
    assign accept     = in_valid && in_ready;
    assign hs         = ovalid_q && out_ready;
    assign beat_nx    = beat_q + 1'b1;
    assign final_beat = (beat_nx == BEAT_LAST);
    assign cap_vld    = (state_q == DRAIN) ? nrn_outvalid : '0;
    assign rd_idx     = (state_q == EMIT) ? idx_q + 1'b1 : '0;

    elm_out_capture #(
        .NUM_NEURONS (NUM_NEURONS),
        .OUT_WIDTH   (OUT_WIDTH),
        .IDX_W       (IDX_W)
    ) u_cap (
        .clk          (clk),
        .rst          (rst),
        .clear        (cap_clear),
        .nrn_outvalid (cap_vld),
        .nrn_out      (nrn_out),
        .rd_idx       (rd_idx),
        .done_all     (done_all),
        .rd_data      (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        din_d     = din_q;
        din_vld_d = 1'b0;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;
        olast_d   = olast_q;
        err_len_d = err_len_q;
        err_to_d  = err_to_q;
        frame_d   = frame_q;
        cap_clear = 1'b0;

        if (accept) begin
            din_d     = in_data;
            din_vld_d = 1'b1;
            beat_d    = final_beat ? '0 : beat_nx;
            state_d   = final_beat ? DRAIN : FEED;
            if (state_q == IDLE) begin
                err_len_d = (in_last != final_beat);
                err_to_d  = 1'b0;
            end else begin
                err_len_d = err_len_q || (in_last != final_beat);
            end
        end

        unique case (state_q)
            DRAIN: begin
                tmr_d = tmr_q + 1'b1;
                if (done_all || tmr_d == TMR_LAST) begin
                    err_to_d = !done_all;
                    state_d  = EMIT;
                    tmr_d    = '0;
                    idx_d    = '0;
                    ovalid_d = 1'b1;
                    odata_d  = rd_data;
                    olast_d  = (IDX_LAST == '0);
                end
            end
            EMIT: begin
                if (hs) begin
                    if (olast_q) begin
                        state_d   = IDLE;
                        cap_clear = 1'b1;
                        frame_d   = frame_q + 16'd1;
                        idx_d     = '0;
                        ovalid_d  = 1'b0;
                        olast_d   = 1'b0;
                        odata_d   = '0;
                    end else begin
                        idx_d   = rd_idx;
                        odata_d = rd_data;
                        olast_d = (rd_idx == IDX_LAST);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            tmr_q     <= '0;
            idx_q     <= '0;
            din_q     <= '0;
            din_vld_q <= 1'b0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            din_q     <= din_d;
            din_vld_q <= din_vld_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            olast_q   <= olast_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            frame_q   <= frame_d;
        end
    end

    assign nrn_input       = din_q;
    assign nrn_input_valid = din_vld_q;
    assign out_data        = odata_q;
    assign out_index       = idx_q;
    assign out_valid       = ovalid_q;
    assign out_last        = olast_q;
    assign busy            = (state_q != IDLE);
    assign err_len         = err_len_q;
    assign err_timeout     = err_to_q;
    assign frame_cnt       = frame_q;

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// Directed and randomized vectors against a transaction-level layer model.
module tb_elm_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 2;
    localparam int DW = 16;
    localparam int OW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] nrn_input;
    logic          nrn_input_valid;
    logic [NN-1:0] nrn_outvalid;
    logic [NN*OW-1:0] nrn_out;
    logic [OW-1:0] out_data;
    logic [$clog2(NN)-1:0] out_index;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          err_len;
    logic          err_timeout;
    logic [15:0]   frame_cnt;

    elm_layer_sequencer #(
        .NUM_INPUTS  (NI),
        .NUM_NEURONS (NN),
        .DATA_WIDTH  (DW),
        .OUT_WIDTH   (OW),
        .TIMEOUT     (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .nrn_input       (nrn_input),
        .nrn_input_valid (nrn_input_valid),
        .nrn_outvalid    (nrn_outvalid),
        .nrn_out         (nrn_out),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .busy            (busy),
        .err_len         (err_len),
        .err_timeout     (err_timeout),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Vector description consumed by run_vector
    logic [DW-1:0] feat [NI];
    logic          lastv [NI];
    int            lat [NN];
    bit            fire [NN];
    logic [OW-1:0] val [NN];
    bit            gap, stall, junk, rnd_rdy;
    int            exp_frame;
    logic [DW-1:0] bc_q [$];

    always @(negedge clk) begin
        if (nrn_input_valid === 1'b1) bc_q.push_back(nrn_input);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        gap = 0; stall = 0; junk = 0; rnd_rdy = 0;
        for (int i = 0; i < NN; i++) fire[i] = 1;
    endtask

    task automatic drive_junk();
        if (junk) begin
            nrn_outvalid = NN'($urandom);
            nrn_out = (NN*OW)'({$urandom, $urandom});
        end else begin
            nrn_outvalid = '0;
            nrn_out = '0;
        end
    endtask

    task automatic run_vector();
        logic          exp_el;
        logic          exp_to;
        bit            all_fire;
        int            exit_k;
        int            got;
        bit            rdy;
        int            stall_left;
        logic [OW-1:0] exp_out [NN];
        logic [NN-1:0] ov;
        logic [NN*OW-1:0] nd;

        bc_q.delete();
        exp_el = 0;
        for (int b = 0; b < NI; b++) begin
            if (gap && b > 0) begin
                in_valid = 0;
                drive_junk();
                @(negedge clk);
            end
            in_valid = 1;
            in_data = feat[b];
            in_last = lastv[b];
            drive_junk();
            chk("in_ready_feed", in_ready, 1);
            @(negedge clk);
            if (lastv[b] != (b == NI - 1)) exp_el = 1;
            chk("err_len_beat", err_len, exp_el);
            if (b == 0) chk("err_to_clear", err_timeout, 0);
        end
        chk("in_ready_full", in_ready, 0);

        all_fire = 1;
        exit_k = 0;
        for (int i = 0; i < NN; i++) begin
            if (!fire[i]) all_fire = 0;
            else if (lat[i] > exit_k) exit_k = lat[i];
        end
        if (!all_fire) exit_k = TO;
        exp_to = !all_fire;

        for (int k = 1; k <= exit_k; k++) begin
            ov = '0;
            nd = junk ? (NN*OW)'({$urandom, $urandom}) : '0;
            for (int i = 0; i < NN; i++) begin
                if (fire[i] && lat[i] == k) begin
                    ov[i] = 1;
                    nd[i*OW +: OW] = val[i];
                end else if (junk && fire[i] && lat[i] < k && $urandom_range(0, 1) == 1) begin
                    ov[i] = 1;
                end
            end
            nrn_outvalid = ov;
            nrn_out = nd;
            in_data = DW'($urandom);
            chk("drain_wait", {busy, in_ready, out_valid}, 3'b100);
            @(negedge clk);
        end
        in_valid = 0;
        in_last = 0;
        nrn_outvalid = '0;
        chk("drain_exit", out_valid, 1);
        chk("err_timeout", err_timeout, exp_to);
        chk("bc_count", bc_q.size(), NI);
        for (int b = 0; b < NI && b < bc_q.size(); b++) begin
            chk("bc_data", bc_q[b], feat[b]);
        end

        for (int i = 0; i < NN; i++) exp_out[i] = fire[i] ? val[i] : '0;
        got = 0;
        stall_left = stall ? 3 : 0;
        for (int c = 0; c < 60 && got < NN; c++) begin
            chk("out_valid", out_valid, 1);
            chk("out_index", out_index, got);
            chk("out_data", out_data, exp_out[got]);
            chk("out_last", out_last, (got == NN - 1));
            if (stall_left > 0) begin
                rdy = 0;
                stall_left--;
            end else begin
                rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1;
            end
            out_ready = rdy;
            drive_junk();
            if (rdy) got++;
            @(negedge clk);
        end
        out_ready = 0;
        nrn_outvalid = '0;
        nrn_out = '0;
        chk("emit_count", got, NN);
        exp_frame++;
        chk("idle_after", {busy, out_valid}, 2'b00);
        chk("frame_cnt", frame_cnt, exp_frame);
        chk("err_len_end", err_len, exp_el);
        chk("err_to_end", err_timeout, exp_to);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; in_last = 0;
        nrn_outvalid = '0; nrn_out = '0; out_ready = 0;
        exp_frame = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_flags", {busy, out_valid, out_last, nrn_input_valid, err_len, err_timeout}, 0);
        chk("rst_data", {nrn_input, out_data, frame_cnt}, 0);
        chk("rst_index", out_index, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        // Basic vector 1..4, neurons at +5/+7
        set_defaults();
        for (int b = 0; b < NI; b++) begin
            feat[b] = DW'(b + 1);
            lastv[b] = (b == NI - 1);
        end
        lat[0] = 5; lat[1] = 7;
        val[0] = 16'h0100; val[1] = 16'h0200;
        run_vector();

        // Gapped input
        set_defaults();
        gap = 1;
        for (int b = 0; b < NI; b++) feat[b] = DW'(16'h1000 + b);
        run_vector();

        // in_last early on beat 2
        set_defaults();
        lastv[0] = 0; lastv[1] = 1; lastv[2] = 0; lastv[3] = 0;
        run_vector();

        // in_last missing on the final beat
        set_defaults();
        lastv[1] = 0;
        run_vector();

        // Neuron 1 never answers
        set_defaults();
        lastv[3] = 1;
        fire[1] = 0;
        lat[0] = 3;
        val[0] = 16'hBEEF;
        run_vector();

        // Output stall on beat 0
        set_defaults();
        stall = 1;
        val[0] = 16'h1234; val[1] = 16'h5678;
        lat[0] = 2; lat[1] = 1;
        run_vector();

        // Reset during FEED after two beats
        for (int b = 0; b < 2; b++) begin
            in_valid = 1; in_data = DW'(16'h00A0 + b); in_last = 0;
            @(negedge clk);
        end
        rst = 1;
        #1;
        chk("midrst_flags", {busy, in_ready, out_valid, nrn_input_valid, err_len, err_timeout}, 0);
        chk("midrst_data", {nrn_input, out_data, frame_cnt}, 0);
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        exp_frame = 0;
        @(negedge clk);
        set_defaults();
        for (int b = 0; b < NI; b++) begin
            feat[b] = DW'(b + 1);
            lastv[b] = (b == NI - 1);
        end
        lat[0] = 5; lat[1] = 7;
        val[0] = 16'h0100; val[1] = 16'h0200;
        run_vector();

        // Randomized vectors
        for (int v = 0; v < 25; v++) begin
            set_defaults();
            gap = $urandom_range(0, 1) == 1;
            junk = $urandom_range(0, 1) == 1;
            rnd_rdy = 1;
            for (int b = 0; b < NI; b++) begin
                feat[b] = DW'($urandom);
                lastv[b] = (b == NI - 1);
                if ($urandom_range(0, 7) == 0) lastv[b] = ~lastv[b];
            end
            for (int i = 0; i < NN; i++) begin
                lat[i] = $urandom_range(1, 7);
                fire[i] = $urandom_range(0, 9) != 0;
                val[i] = OW'($urandom);
            end
            run_vector();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elm_layer_sequencer.md
Name: elm_layer_sequencer

Overview:
- Sequences one hidden layer of ELM neurons: accepts one input feature vector on a valid/ready stream and broadcasts each feature to all neurons as a single-cycle-valid beat.
- Waits for every neuron's outvalid pulse and captures each neuron's activation output.
- Serialises the captured outputs on a valid/ready output stream, one neuron per beat.
- Sits between the AXI input-stream adapter and the layer's neuron array; weight/bias loading is outside this block.

Parameters:
- NUM_INPUTS, 128, features per vector; equals numWeight of every neuron.
- NUM_NEURONS, 16, neurons in the layer.
- DATA_WIDTH, 16, feature width (`dataWidth).
- OUT_WIDTH, 16, neuron output width (`ROM_bitwidth).
- TIMEOUT, 64, DRAIN cycles allowed before declaring a timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  feature value
- in_valid  in  1  feature beat valid
- in_last  in  1  marks the last feature of the vector
- in_ready  out  1  feature beat accepted when in_valid&in_ready
- nrn_input  out  DATA_WIDTH  broadcast feature to neurons (myinput)
- nrn_input_valid  out  1  broadcast valid (myinputValid)
- nrn_outvalid  in  NUM_NEURONS  per-neuron outvalid
- nrn_out  in  NUM_NEURONS*OUT_WIDTH  per-neuron out; neuron i occupies bits [i*OUT_WIDTH +: OUT_WIDTH]
- out_data  out  OUT_WIDTH  serialised neuron output
- out_index  out  $clog2(NUM_NEURONS)  neuron number of out_data
- out_valid  out  1  output beat valid
- out_last  out  1  high on the beat for neuron NUM_NEURONS-1
- out_ready  in  1  output sink ready
- busy  out  1  state != IDLE
- err_len  out  1  sticky in_last mismatch
- err_timeout  out  1  sticky DRAIN timeout
- frame_cnt  out  16  count of completed vectors; wraps

Behaviour:
- Reset: all outputs, counters, capture registers and the done mask go to 0; state goes to IDLE. Reset asserted mid-operation aborts the vector immediately, with no partial output.
- States are IDLE, FEED, DRAIN and EMIT.
- IDLE: in_ready=1. The first accepted beat clears err_len and err_timeout, sets beat_cnt=1 and moves to FEED.
- FEED: in_ready=1. Each accepted beat increments beat_cnt.
- Gaps in in_valid are legal in FEED.
- Broadcast is registered: nrn_input/nrn_input_valid are driven 1 cycle after acceptance. nrn_input_valid=0 on every cycle without an accepted beat.
- Leaving FEED: the accepted beat with beat_cnt reaching NUM_INPUTS moves the block to DRAIN. in_ready is combinationally 0 from that point, so no further beat is accepted.
- err_len is set if in_last=1 on any accepted beat other than beat NUM_INPUTS, or if in_last=0 on beat NUM_INPUTS.
- The vector length is always NUM_INPUTS; in_last is never used to terminate early.
- DRAIN: in_ready=0 and a timer counts up.
  - Each cycle, for every bit i with nrn_outvalid[i]=1 and done[i]=0, capture nrn_out slice i into cap[i] and set done[i].
  - Repeated pulses on an already-done neuron are ignored.
  - When done is all ones (including the capture cycle itself), the next state is EMIT.
  - If the timer reaches TIMEOUT first: set err_timeout and go to EMIT. Uncaptured slots emit 0.
- nrn_outvalid pulses seen in IDLE, FEED or EMIT are ignored.
- EMIT: idx starts at 0. out_valid=1, out_data=cap[idx], out_index=idx, out_last=(idx==NUM_NEURONS-1).
  - Outputs are registered and held stable while out_valid&!out_ready.
  - A handshake advances idx.
  - The handshake with out_last=1 clears the done mask, increments frame_cnt (wrapping 0xFFFF to 0) and returns to IDLE. out_valid drops on the next cycle.
- Throughput: NUM_INPUTS + neuron latency + NUM_NEURONS cycles per vector minimum, with no overlap between vectors.

Decomposition:
- Package elm_seq_pkg holds the state enum (IDLE/FEED/DRAIN/EMIT), the $clog2 width constants for beat_cnt, idx and timer, and the default parameter values.
- One sub-module: elm_out_capture holds the done mask and the cap[] register bank. Its interface is clear, nrn_outvalid, nrn_out, a read index, done_all and rd_data.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=2. Feed 1,2,3,4 with in_last on beat 4. Neuron models pulse outvalid at +5 and +7 cycles with outputs 0x0100 and 0x0200. Required response: out beats (0,0x0100) then (1,0x0200,last), frame_cnt=1, errors 0.
- Gaps in in_valid every other cycle: nrn_input_valid carries exactly 4 pulses with the same data order, and in_ready=0 after beat 4 even with in_valid held high.
- in_last on beat 2: err_len=1, the block still consumes 4 beats and emits normally. err_len clears on the first beat of the next vector.
- Neuron 1 never pulses, TIMEOUT=8: DRAIN exits after 8 cycles with err_timeout=1, and beat 1 carries out_data=0.
- out_ready held low for 3 cycles on beat 0: out_data and out_index are held stable, and no beat is lost or duplicated.
- rst asserted during FEED after 2 beats: all outputs are 0 and the state is IDLE within the same cycle. The next full vector completes with frame_cnt=1.
